fp_issue_scoreboard: RTL
========================

FP_ISSUE_SCOREBOARD -- requirements
Module: fp_issue_scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, max in-flight FP ops writing frd (range 1..15).
REQ-002 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have ports dec_valid_i input 1 and dec_ready_o output 1: decode-to-scoreboard handshake.
REQ-005 SHALL have ports dec_rs1_i, dec_rs2_i, dec_rs3_i, dec_rd_i  input  5 each: register indices from inst[19:15], [24:20], [31:27], [11:7].
REQ-006 SHALL have ports dec_uses_frs1_i, dec_uses_frs2_i, dec_uses_frs3_i, dec_writes_frd_i, dec_illegal_i  input  1 each: decoder flags; dec_illegal_i is the decoder's illegal_fp_fmt.
REQ-007 SHALL have ports iss_valid_o output 1, iss_ready_i input 1, iss_rd_o output 5, iss_writes_frd_o output 1: issue handshake to the FPU.
REQ-008 SHALL have ports wb_valid_i input 1 and wb_rd_i input 5: FPU writeback of an frd.
REQ-009 SHALL have ports illegal_o output 1 (one-cycle illegal pulse), busy_o output 32 (scoreboard vector), outstanding_o output 4 (in-flight count).

Function
REQ-010 SHALL hold at most one instruction in a holding register; state EMPTY or HELD.
REQ-011 SHALL drive dec_ready_o = EMPTY or (HELD and issue fires this cycle).
REQ-012 SHALL capture an instruction on dec_valid_i and dec_ready_o with dec_illegal_i=0: EMPTY->HELD, or HELD->HELD when replacing the instruction issuing that cycle.
REQ-013 SHALL consume an instruction with dec_illegal_i=1 without storing it, pulse illegal_o for exactly the next cycle, and leave busy_o unchanged.
REQ-014 SHALL raise a hazard when any used source has busy_o[rsN]=1 (RAW), when writes_frd=1 and busy_o[rd]=1 (WAW), or when writes_frd=1 and outstanding_o=MAX_OUTSTANDING.
REQ-015 SHALL drive iss_valid_o = HELD and no hazard; iss_rd_o and iss_writes_frd_o come from the held entry.
REQ-016 SHALL treat iss_valid_o and iss_ready_i high together as an issue fire; HELD->EMPTY unless refilled the same cycle.
REQ-017 SHALL keep iss_valid_o high and the held entry stable, once asserted, until the fire.
REQ-018 SHALL set busy_o[rd] and increment outstanding_o on the cycle after an issue fire with writes_frd=1.
REQ-019 SHALL clear busy_o[wb_rd_i] and decrement outstanding_o when wb_valid_i=1 and that bit is set; writeback to a non-busy register SHALL be ignored with no counter change.
REQ-020 SHALL resolve an issue set and a writeback clear of the same register in the same cycle as set-wins, with outstanding_o net unchanged.
REQ-021 SHALL track f0..f31 identically (no hardwired zero register).
REQ-022 SHALL leave a non-writing op (FSW/FSD, FEQ, FMV.X.W, FCVT.W.*) untouched in busy_o and outstanding_o.

Reset
REQ-023 SHALL on rst_i=1 immediately force state EMPTY, busy_o=0, outstanding_o=0, illegal_o=0, iss_valid_o=0, dec_ready_o=1.
REQ-024 SHALL discard any held instruction on reset mid-operation and ignore wb_valid_i while rst_i=1.

Configuration
REQ-025 SHALL, with macro FP_SCB_WB_BYPASS_EN defined, evaluate hazards against busy_o with the same-cycle writeback bit removed, so a dependant issues in the writeback cycle.
REQ-026 SHALL, without FP_SCB_WB_BYPASS_EN, evaluate hazards against registered busy_o only, so a dependant issues no earlier than the cycle after writeback.

Verification
REQ-027 SHALL cover: fadd.s f5 issued (ready=1), then fmul.s f7,f5,f2 -> iss_valid_o=0 until wb_rd_i=5; issue in the same cycle with bypass, one cycle later without.
REQ-028 SHALL cover: fsgnj.s f10 in flight, then a second write to f10 -> WAW stall; released by wb_rd_i=10.
REQ-029 SHALL cover: MAX_OUTSTANDING=4, five writers to f1..f5 with no wb -> fifth held, outstanding_o=4; one wb -> fifth issues, outstanding_o returns to 4.
REQ-030 SHALL cover: dec_illegal_i=1 (fmt=H) -> illegal_o=1 for one cycle, busy_o and outstanding_o unchanged, dec_ready_o=1.
REQ-031 SHALL cover: iss_ready_i=0 for 3 cycles with a held fle.s -> iss_valid_o and iss_rd_o stable, dec_ready_o=0; no busy bit set (writes_frd=0).
REQ-032 SHALL cover: rst_i pulsed mid-cycle with busy_o=0x0000_0024, outstanding_o=2 -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/fp_issue_scoreboard_if.sv
// Decode / issue / writeback bundle around the FP issue scoreboard.
// slave = scoreboard side, master = decoder/FPU side.
interface fp_issue_scoreboard_if;
  logic        dec_valid_i;
  logic        dec_ready_o;
  logic [4:0]  dec_rs1_i;
  logic [4:0]  dec_rs2_i;
  logic [4:0]  dec_rs3_i;
  logic [4:0]  dec_rd_i;
  logic        dec_uses_frs1_i;
  logic        dec_uses_frs2_i;
  logic        dec_uses_frs3_i;
  logic        dec_writes_frd_i;
  logic        dec_illegal_i;
  logic        iss_valid_o;
  logic        iss_ready_i;
  logic [4:0]  iss_rd_o;
  logic        iss_writes_frd_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        illegal_o;
  logic [31:0] busy_o;
  logic [3:0]  outstanding_o;

  modport slave (
    input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs3_i, dec_rd_i,
           dec_uses_frs1_i, dec_uses_frs2_i, dec_uses_frs3_i,
           dec_writes_frd_i, dec_illegal_i, iss_ready_i, wb_valid_i, wb_rd_i,
    output dec_ready_o, iss_valid_o, iss_rd_o, iss_writes_frd_o,
           illegal_o, busy_o, outstanding_o
  );

  modport master (
    output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs3_i, dec_rd_i,
           dec_uses_frs1_i, dec_uses_frs2_i, dec_uses_frs3_i,
           dec_writes_frd_i, dec_illegal_i, iss_ready_i, wb_valid_i, wb_rd_i,
    input  dec_ready_o, iss_valid_o, iss_rd_o, iss_writes_frd_o,
           illegal_o, busy_o, outstanding_o
  );
endinterface

// File: rtl/fp_issue_scoreboard.sv
// FP issue scoreboard: one-entry holding register, RAW/WAW/capacity hazards on f0..f31.
// Define FP_SCB_WB_BYPASS_EN to let a same-cycle writeback release a dependant.
module fp_issue_scoreboard #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  fp_issue_scoreboard_if.slave  io
);

  typedef enum logic {EMPTY, HELD} state_e;

  state_e      state_q, state_d;
  logic [31:0] busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        illegal_q, illegal_d;
  logic [4:0]  rs1_q, rs2_q, rs3_q, rd_q;
  logic        u1_q, u2_q, u3_q, wr_q;

  logic [31:0] wb_clr, iss_set, busy_eff;
  logic        wb_hit, hazard, iss_valid, dec_ready, fire, accept, capture;

  always_comb begin
    wb_hit = io.wb_valid_i & busy_q[io.wb_rd_i];
    wb_clr = '0;
    if (wb_hit) wb_clr[io.wb_rd_i] = 1'b1;
`ifdef FP_SCB_WB_BYPASS_EN
    busy_eff = busy_q & ~wb_clr;
`else
    busy_eff = busy_q;
`endif
    hazard = (u1_q & busy_eff[rs1_q]) | (u2_q & busy_eff[rs2_q]) |
             (u3_q & busy_eff[rs3_q]) |
             (wr_q & (busy_eff[rd_q] | (cnt_q == 4'(MAX_OUTSTANDING))));
    iss_valid = (state_q == HELD) & ~hazard;
    fire      = iss_valid & io.iss_ready_i;
    dec_ready = (state_q == EMPTY) | fire;
    accept    = io.dec_valid_i & dec_ready;
    capture   = accept & ~io.dec_illegal_i;
    illegal_d = accept & io.dec_illegal_i;

    state_d = state_q;
    if (capture)   state_d = HELD;
    else if (fire) state_d = EMPTY;

    // Set is applied after the clear so an issue to the register being written back wins.
    iss_set = '0;
    if (fire & wr_q) iss_set[rd_q] = 1'b1;
    busy_d = (busy_q & ~wb_clr) | iss_set;
    cnt_d  = cnt_q + {3'b000, fire & wr_q} - {3'b000, wb_hit};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      busy_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rs3_q     <= '0;
      rd_q      <= '0;
      u1_q      <= 1'b0;
      u2_q      <= 1'b0;
      u3_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      if (capture) begin
        rs1_q <= io.dec_rs1_i;
        rs2_q <= io.dec_rs2_i;
        rs3_q <= io.dec_rs3_i;
        rd_q  <= io.dec_rd_i;
        u1_q  <= io.dec_uses_frs1_i;
        u2_q  <= io.dec_uses_frs2_i;
        u3_q  <= io.dec_uses_frs3_i;
        wr_q  <= io.dec_writes_frd_i;
      end
    end
  end

  assign io.dec_ready_o      = dec_ready;
  assign io.iss_valid_o      = iss_valid;
  assign io.iss_rd_o         = rd_q;
  assign io.iss_writes_frd_o = wr_q;
  assign io.illegal_o        = illegal_q;
  assign io.busy_o           = busy_q;
  assign io.outstanding_o    = cnt_q;

endmodule
